// File: rtl/spi_frame_pkg.sv
// Shared constants, status-bit positions and FSM encoding for the framed SPI master.
package spi_frame_pkg;

  localparam int FRAME_BITS = 32;
  localparam logic [7:0] OPCODE_INIT = 8'h01;

  localparam int STAT_RX_OK     = 5;
  localparam int STAT_HAS_DATA  = 6;
  localparam int STAT_SEND_MASK = 7;

  typedef enum logic [2:0] {
    ST_INIT_GAP,
    ST_SS_SETUP,
    ST_SHIFT,
    ST_SS_HOLD,
    ST_GAP,
    ST_IDLE
  } state_e;

  // The payload field is only meaningful when the slave sets both data flags.
  function automatic logic has_data(input logic [7:0] status);
    return status[STAT_HAS_DATA] & status[STAT_SEND_MASK];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: one bit period is HALF_DIV clk low followed by HALF_DIV clk high.
// HALF_DIV must be at least 4 so the slave's 2-flop synchronizer sees every phase.
module spi_sck_gen #(
  parameter int HALF_DIV = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic tick_rise_o,
  output logic tick_sample_o,
  output logic tick_fall_o
);

  localparam int CW = $clog2(2 * HALF_DIV);
  localparam logic [CW-1:0] RISE_AT = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] HIGH_AT = CW'(HALF_DIV);
  localparam logic [CW-1:0] LAST_AT = CW'(2 * HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST_AT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last clk of the high phase both samples MISO and precedes the falling edge.
  assign sck_o         = en_i && (cnt_q >= HIGH_AT);
  assign tick_rise_o   = en_i && (cnt_q == RISE_AT);
  assign tick_sample_o = en_i && (cnt_q == LAST_AT);
  assign tick_fall_o   = en_i && (cnt_q == LAST_AT);

endmodule

// File: rtl/spi_frame_master.sv
// Host-side master for the 32-bit framed SPI slave link: sends a link-init frame
// after reset, then one full-duplex frame per accepted command.
module spi_frame_master
  import spi_frame_pkg::*;
#(
  parameter int HALF_DIV = 8,
  parameter int SS_GUARD = 8,
  parameter logic [7:0] INIT_OPCODE = OPCODE_INIT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        SPI_SCK,
  output logic        SPI_SS,
  output logic        SPI_MOSI,
  input  logic        SPI_MISO,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_status,
  output logic [23:0] rsp_data,
  output logic        rsp_has_data,
  output logic        link_up,
  output logic        busy
);

  localparam int GW = $clog2(SS_GUARD + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(SS_GUARD - 1);
  localparam logic [5:0] BITS_DONE = 6'(FRAME_BITS);

  state_e state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [5:0] bit_q, bit_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_status_q, rsp_status_d;
  logic [23:0] rsp_data_q, rsp_data_d;
  logic rsp_has_data_q, rsp_has_data_d;
  logic link_up_q, link_up_d;
  logic busy_q;

  logic guard_done;
  logic [FRAME_BITS-1:0] rx_next;
  logic rx_has;
  logic sck;
  logic tick_rise, tick_sample, tick_fall;

  spi_sck_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_sck_gen (
    .clk          (clk),
    .reset        (reset),
    .en_i         (state_q == ST_SHIFT),
    .sck_o        (sck),
    .tick_rise_o  (tick_rise),
    .tick_sample_o(tick_sample),
    .tick_fall_o  (tick_fall)
  );

  assign guard_done = (guard_q == GUARD_LAST);
  assign rx_next    = {SPI_MISO, rx_q[FRAME_BITS-1:1]};
  assign rx_has     = has_data(rx_next[7:0]);

  // bit_q counts rising edges, so the frame ends on the sample after the 32nd rise.
  always_comb begin
    state_d        = state_q;
    guard_d        = guard_q;
    bit_d          = bit_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    rsp_valid_d    = 1'b0;
    rsp_status_d   = rsp_status_q;
    rsp_data_d     = rsp_data_q;
    rsp_has_data_d = rsp_has_data_q;
    link_up_d      = link_up_q;

    unique case (state_q)
      ST_INIT_GAP: begin
        if (guard_done) begin
          guard_d = '0;
          tx_d    = {24'h0, INIT_OPCODE};
          state_d = ST_SS_SETUP;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_SS_SETUP: begin
        if (guard_done) begin
          guard_d = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (tick_rise) begin
          bit_d = bit_q + 1'b1;
        end
        if (tick_fall) begin
          tx_d = {1'b0, tx_q[FRAME_BITS-1:1]};
        end
        if (tick_sample) begin
          rx_d = rx_next;
          if (bit_q == BITS_DONE) begin
            state_d        = ST_SS_HOLD;
            rsp_valid_d    = 1'b1;
            rsp_status_d   = rx_next[7:0];
            rsp_has_data_d = rx_has;
            rsp_data_d     = rx_has ? rx_next[31:8] : 24'h0;
            // Only the init frame runs while the link is down.
            if (!link_up_q && rx_next[STAT_RX_OK]) begin
              link_up_d = 1'b1;
            end
          end
        end
      end
      ST_SS_HOLD: begin
        if (guard_done) begin
          guard_d = '0;
          state_d = link_up_q ? ST_GAP : ST_INIT_GAP;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (guard_done) begin
          guard_d = '0;
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          tx_d    = cmd_data;
          guard_d = '0;
          state_d = ST_SS_SETUP;
        end
      end
      default: begin
        state_d = ST_INIT_GAP;
        guard_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_INIT_GAP;
      guard_q        <= '0;
      bit_q          <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_status_q   <= '0;
      rsp_data_q     <= '0;
      rsp_has_data_q <= 1'b0;
      link_up_q      <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      guard_q        <= guard_d;
      bit_q          <= bit_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_status_q   <= rsp_status_d;
      rsp_data_q     <= rsp_data_d;
      rsp_has_data_q <= rsp_has_data_d;
      link_up_q      <= link_up_d;
      busy_q         <= (state_d != ST_IDLE);
    end
  end

  assign SPI_SCK      = sck;
  assign SPI_SS       = !((state_q == ST_SS_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_SS_HOLD));
  assign SPI_MOSI     = (state_q == ST_SHIFT) && tx_q[0];
  assign cmd_ready    = (state_q == ST_IDLE) && link_up_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_status   = rsp_status_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_has_data = rsp_has_data_q;
  assign link_up      = link_up_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master with a behavioural SPI slave and a
// word-level response model.
module tb_spi_frame_master;

  localparam int H = 4;
  localparam int G = 6;
  localparam int FRAME_PERIOD = 64 * H + 3 * G + 1;
  localparam logic [31:0] INIT_WORD = 32'h0000_0001;
  localparam int BUDGET = 4 * FRAME_PERIOD;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SPI_SCK, SPI_SS, SPI_MOSI;
  logic SPI_MISO = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [31:0] cmd_data = 32'h0;
  logic rsp_valid;
  logic [7:0] rsp_status;
  logic [23:0] rsp_data;
  logic rsp_has_data, link_up, busy;

  int checks = 0;
  int failures = 0;
  int rsp_count = 0;

  always #5 clk = ~clk;

  spi_frame_master #(
    .HALF_DIV   (H),
    .SS_GUARD   (G),
    .INIT_OPCODE(8'h01)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .SPI_SCK     (SPI_SCK),
    .SPI_SS      (SPI_SS),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_status  (rsp_status),
    .rsp_data    (rsp_data),
    .rsp_has_data(rsp_has_data),
    .link_up     (link_up),
    .busy        (busy)
  );

  // Slave: latches its reply while deselected, captures MOSI on SCK rise and
  // presents the matching reply bit a few clk after that rise.
  logic [31:0] slave_resp = 32'h0;
  logic [31:0] cur_resp = 32'h0;
  logic [31:0] mosi_cap = 32'h0;
  int sbit = 0;
  int miso_idx = 0;
  int dly = 0;
  logic sck_prev = 1'b0;

  always @(posedge clk) begin
    if (SPI_SS) begin
      sbit = 0;
      dly = 0;
      mosi_cap = 32'h0;
      cur_resp = slave_resp;
    end else begin
      if (dly != 0) begin
        dly--;
        if (dly == 0) SPI_MISO <= cur_resp[miso_idx];
      end
      if (SPI_SCK && !sck_prev && sbit < 32) begin
        mosi_cap[sbit] = SPI_MOSI;
        miso_idx = sbit;
        sbit++;
        dly = 2;
      end
    end
    sck_prev = SPI_SCK;
  end

  always @(negedge clk) if (rsp_valid) rsp_count++;

  // Reference: status is the low byte, payload the upper three bytes, and the
  // payload counts only when status is at least 0xC0 (both top flags set).
  function automatic void model_rsp(input logic [31:0] w, output logic [7:0] st,
                                    output logic has, output logic [23:0] d);
    st = 8'(w % 256);
    has = (st >= 8'hC0);
    d = has ? 24'(w / 256) : 24'd0;
  endfunction

  task automatic wait_rsp(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(input int budget, output bit ok, output int waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      waited = i + 1;
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_cmd(input logic [31:0] c, output bit ok);
    int w;
    wait_ready(BUDGET, ok, w);
    if (!ok) return;
    cmd_valid = 1'b1;
    cmd_data = c;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    slave_resp = $urandom & 32'hFFFF_FFDF;
    repeat (3) @(negedge clk);
    checks++;
    if ({SPI_SCK, SPI_SS, SPI_MOSI, cmd_ready, rsp_valid, rsp_has_data, link_up, busy} !== 8'b0100_0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got %b expected 01000000",
               {SPI_SCK, SPI_SS, SPI_MOSI, cmd_ready, rsp_valid, rsp_has_data, link_up, busy});
    end
    checks++;
    if (rsp_status !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h expected 00", rsp_status);
    end
    checks++;
    if (rsp_data !== 24'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 000000", rsp_data);
    end
  endtask

  task automatic test_init_retry();
    bit ok;
    logic [7:0] est;
    logic eh;
    logic [23:0] ed;
    @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 2; a++) begin
      model_rsp(slave_resp, est, eh, ed);
      wait_rsp(BUDGET, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("[TB] FAIL init_retry_timeout: no rsp_valid on attempt %0d", a);
        return;
      end
      checks++;
      if (mosi_cap !== INIT_WORD || rsp_status !== est || link_up !== 1'b0) begin
        failures++;
        $display("[TB] FAIL init_retry_frame: mosi=%h status=%h link=%b expected mosi=%h status=%h link=0",
                 mosi_cap, rsp_status, link_up, INIT_WORD, est);
      end
      if (a == 1) slave_resp = $urandom | 32'h0000_0020;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("[TB] FAIL init_retry_pulse: rsp_valid=%b expected 0 one cycle later", rsp_valid);
      end
    end
    checks++;
    if (rsp_count !== 2 || cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_retry_count: pulses=%0d cmd_ready=%b expected 2 and 0", rsp_count, cmd_ready);
    end
  endtask

  task automatic test_init_ok();
    bit ok;
    int waited;
    logic [7:0] est;
    logic eh;
    logic [23:0] ed;
    model_rsp(slave_resp, est, eh, ed);
    wait_rsp(BUDGET, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL init_ok_timeout: no rsp_valid");
      return;
    end
    checks++;
    if (mosi_cap !== INIT_WORD || rsp_status !== est || rsp_has_data !== eh || rsp_data !== ed) begin
      failures++;
      $display("[TB] FAIL init_ok_rsp: mosi=%h st=%h has=%b d=%h expected %h %h %b %h",
               mosi_cap, rsp_status, rsp_has_data, rsp_data, INIT_WORD, est, eh, ed);
    end
    checks++;
    if (link_up !== 1'b1) begin
      failures++;
      $display("[TB] FAIL init_ok_link: link_up=%b expected 1", link_up);
    end
    wait_ready(BUDGET, ok, waited);
    checks++;
    if (!ok || waited != 2 * G || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL init_ok_ready: ready after %0d cycles busy=%b expected %0d and 0", waited, busy, 2 * G);
    end
  endtask

  task automatic test_command();
    bit ok;
    logic [31:0] c;
    logic [7:0] est;
    logic eh;
    logic [23:0] ed;
    slave_resp = {24'hCAFE77, 8'hE0};
    send_cmd(32'hA5C33C02, ok);
    if (ok) wait_rsp(BUDGET, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL cmd_fixed_timeout: no handshake or rsp_valid");
      return;
    end
    checks++;
    if (mosi_cap !== 32'hA5C33C02 || rsp_status !== 8'hE0 || rsp_has_data !== 1'b1 || rsp_data !== 24'hCAFE77) begin
      failures++;
      $display("[TB] FAIL cmd_fixed: mosi=%h st=%h has=%b d=%h expected a5c33c02 e0 1 cafe77",
               mosi_cap, rsp_status, rsp_has_data, rsp_data);
    end
    for (int n = 0; n < 5; n++) begin
      c = $urandom;
      slave_resp = $urandom;
      model_rsp(slave_resp, est, eh, ed);
      send_cmd(c, ok);
      if (ok) wait_rsp(BUDGET, ok);
      checks++;
      if (!ok || mosi_cap !== c || rsp_status !== est || rsp_has_data !== eh || rsp_data !== ed || link_up !== 1'b1) begin
        failures++;
        $display("[TB] FAIL cmd_random_%0d: ok=%b mosi=%h st=%h has=%b d=%h link=%b expected %h %h %b %h 1",
                 n, ok, mosi_cap, rsp_status, rsp_has_data, rsp_data, link_up, c, est, eh, ed);
      end
    end
  endtask

  task automatic test_no_data();
    bit ok;
    logic [31:0] r;
    logic [7:0] est;
    logic eh;
    logic [23:0] ed;
    for (int n = 0; n < 3; n++) begin
      r = $urandom | 32'h00FF_0F00;
      r = (n == 0) ? (r & 32'hFFFF_FF3F) : (n == 1) ? (r & 32'hFFFF_FF7F) : (r & 32'hFFFF_FFBF);
      slave_resp = r;
      model_rsp(r, est, eh, ed);
      send_cmd($urandom, ok);
      if (ok) wait_rsp(BUDGET, ok);
      checks++;
      if (!ok || rsp_status !== est || rsp_has_data !== 1'b0 || rsp_data !== 24'h0) begin
        failures++;
        $display("[TB] FAIL no_data_%0d: ok=%b st=%h has=%b d=%h expected %h 0 000000",
                 n, ok, rsp_status, rsp_has_data, rsp_data, est);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit hit;
    int c0;
    slave_resp = $urandom | 32'h0000_0020;
    send_cmd($urandom, ok);
    hit = 1'b0;
    for (int i = 0; ok && i < BUDGET; i++) begin
      @(negedge clk);
      if (sbit == 17) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || SPI_SS !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_reach_bit17: reached=%b ss=%b expected 1 and 0", hit, SPI_SS);
      return;
    end
    reset = 1'b1;
    c0 = rsp_count;
    @(negedge clk);
    checks++;
    if (SPI_SS !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_ss: ss=%b rsp_valid=%b expected 1 and 0", SPI_SS, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (link_up !== 1'b0 || cmd_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_link: link_up=%b cmd_ready=%b expected 0 and 0", link_up, cmd_ready);
    end
    reset = 1'b0;
    wait_rsp(BUDGET, ok);
    @(negedge clk);
    checks++;
    if (!ok || mosi_cap !== INIT_WORD || rsp_count != c0 + 1 || link_up !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_reinit: ok=%b mosi=%h pulses=%0d link=%b expected 1 %h %0d 1",
               ok, mosi_cap, rsp_count - c0, link_up, INIT_WORD, 1);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int w;
    int cyc = 0;
    int nf = 0;
    int falls[4];
    logic prev_ss = 1'b1;
    logic prev_sck = 1'b0;
    int run = 0;
    bit seen_rise = 1'b0;
    int hi_runs = 0;
    int sck_bad = 0;
    int viol = 0;
    int rdy = 0;
    slave_resp = $urandom;
    wait_ready(BUDGET, ok, w);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL b2b_start: cmd_ready never rose");
      return;
    end
    cmd_valid = 1'b1;
    cmd_data = $urandom;
    for (int i = 0; i < 5 * FRAME_PERIOD && nf < 4; i++) begin
      @(negedge clk);
      cyc++;
      if (cmd_ready && (busy || !SPI_SS)) viol++;
      if (cmd_ready) rdy++;
      if (prev_ss && !SPI_SS) begin
        falls[nf] = cyc;
        nf++;
      end
      if (!SPI_SS) begin
        if (SPI_SCK == prev_sck) run++;
        else begin
          if (prev_sck) begin
            hi_runs++;
            if (run != H) sck_bad++;
          end else if (seen_rise && run != H) sck_bad++;
          if (SPI_SCK) seen_rise = 1'b1;
          run = 1;
        end
      end else begin
        seen_rise = 1'b0;
        run = 0;
      end
      prev_sck = SPI_SCK;
      prev_ss = SPI_SS;
    end
    cmd_valid = 1'b0;
    checks++;
    if (nf != 4) begin
      failures++;
      $display("[TB] FAIL b2b_frames: saw %0d SS falls expected 4", nf);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (falls[k+1] - falls[k] != FRAME_PERIOD) begin
        failures++;
        $display("[TB] FAIL b2b_period_%0d: got %0d cycles expected %0d", k, falls[k+1] - falls[k], FRAME_PERIOD);
      end
    end
    checks++;
    if (viol != 0 || rdy != 3) begin
      failures++;
      $display("[TB] FAIL b2b_ready: busy-overlap=%0d ready-cycles=%0d expected 0 and 3", viol, rdy);
    end
    checks++;
    if (sck_bad != 0 || hi_runs != 96) begin
      failures++;
      $display("[TB] FAIL b2b_sck: bad-phases=%0d high-phases=%0d expected 0 and 96", sck_bad, hi_runs);
    end
    wait_rsp(BUDGET, ok);
    wait_ready(BUDGET, ok, w);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL b2b_drain: cmd_ready did not return after last frame");
    end
  endtask

  initial begin
    test_reset();
    test_init_retry();
    test_init_ok();
    test_command();
    test_no_data();
    test_reset_mid_frame();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
